axis_hist_ram_sink: RTL and testbench

AXI-Stream write-command consumer for the histogram datapath. It accepts the 32-bit beats the histogram block emits (`{8'h0, addr[7:0], 8'h0, data[7:0]}`), buffers them in a small FIFO and commits each one to an internal 256x8 RAM. On request it streams a RAM window back out on an AXI-Stream master, using the same beat format, for host or checker readback. After reset it clears the RAM itself, so bin counts and bin data start at zero.

---
 rtl/axis_hist_ram_sink_if.sv | 21 ++
 rtl/axis_hist_ram_sink.sv | 170 +++++++++++++++++
 tb/tb_axis_hist_ram_sink.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_hist_ram_sink_if.sv
// AXI-Stream bundle for axis_hist_ram_sink: command input (s_axis_*) and dump output (m_axis_*).
// The slave modport is the sink's view; master is the view of whatever drives it.
interface axis_hist_ram_sink_if;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/axis_hist_ram_sink.sv
// Histogram write-command sink: FIFO-buffered commits into a 256x8 RAM, self-clear after reset,
// windowed AXI-Stream dump readback. Define SINK_RDPORT_EN to enable the rd_addr/rd_data side port.
module axis_hist_ram_sink #(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                       aclk,
  input  logic                       areset,
  axis_hist_ram_sink_if.slave        axis,
  input  logic                       dump_start,
  input  logic [7:0]                 dump_base,
  input  logic [8:0]                 dump_len,
  output logic                       busy,
  output logic [31:0]                wr_count,
  output logic                       err_fmt,
  input  logic [7:0]                 rd_addr,
  output logic [7:0]                 rd_data
);
  localparam int         PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [7:0] LAST_ADDR = 8'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, DUMP_RD, DUMP_OUT} state_t;

  function automatic logic fmt_ok(input logic [31:0] beat);
    return (beat[31:24] == 8'h00) && (beat[15:8] == 8'h00);
  endfunction

  function automatic logic [8:0] sat_len(input logic [8:0] len);
    return (len > 9'd256) ? 9'd256 : len;
  endfunction

  state_t      state, state_nx;
  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wptr, rptr;
  logic        fifo_full, fifo_empty, push, pop;
  logic [31:0] beat_p0;
  logic        vld_p0;
  logic [7:0]  mem [MEM_DEPTH];
  logic [7:0]  clr_addr, cur_addr, rdata_q;
  logic [8:0]  remaining;
  logic        dump_pending, dump_acc, dump_done;
  logic        rd_en, s_ready, m_valid, m_last, busy_c;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                      (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
  assign push       = axis.s_axis_tvalid && s_ready;
  assign dump_acc   = dump_start && !areset && (state != CLEAR) && !busy_c &&
                      (dump_len != 9'd0);

  assign axis.s_axis_tready = s_ready;
  assign axis.m_axis_tvalid = m_valid;
  assign axis.m_axis_tlast  = m_last;
  assign axis.m_axis_tdata  = m_valid ? {8'h00, cur_addr, 8'h00, rdata_q} : 32'h0;
  assign busy               = busy_c;

  always_ff @(posedge aclk) begin
    if (areset) state <= CLEAR;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    busy_c    = 1'b0;
    pop       = 1'b0;
    rd_en     = 1'b0;
    dump_done = 1'b0;
    case (state)
      CLEAR: begin
        busy_c = 1'b1;
        if (clr_addr == LAST_ADDR) state_nx = IDLE;
      end
      IDLE: begin
        s_ready = !fifo_full && !dump_pending;
        pop     = !fifo_empty;
        busy_c  = dump_pending;
        // Dump waits until both the FIFO and the commit stage are empty.
        if (dump_pending && fifo_empty && !vld_p0) state_nx = DUMP_RD;
      end
      DUMP_RD: begin
        busy_c   = 1'b1;
        rd_en    = 1'b1;
        state_nx = DUMP_OUT;
      end
      DUMP_OUT: begin
        busy_c  = 1'b1;
        m_valid = 1'b1;
        m_last  = (remaining == 9'd1);
        if (axis.m_axis_tready) begin
          if (remaining == 9'd1) begin
            state_nx  = IDLE;
            dump_done = 1'b1;
          end else begin
            state_nx = DUMP_RD;
          end
        end
      end
      default: state_nx = CLEAR;
    endcase
    if (areset) begin
      s_ready = 1'b0;
      m_valid = 1'b0;
      m_last  = 1'b0;
      busy_c  = 1'b0;
      pop     = 1'b0;
      rd_en   = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wptr         <= '0;
      rptr         <= '0;
      vld_p0       <= 1'b0;
      wr_count     <= 32'd0;
      err_fmt      <= 1'b0;
      clr_addr     <= 8'd0;
      cur_addr     <= 8'd0;
      remaining    <= 9'd0;
      dump_pending <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      vld_p0 <= pop;
      if (vld_p0) begin
        if (fmt_ok(beat_p0)) wr_count <= wr_count + 32'd1;
        else                 err_fmt  <= 1'b1;
      end
      if (state == CLEAR) clr_addr <= clr_addr + 8'd1;
      if (dump_acc) begin
        dump_pending <= 1'b1;
        cur_addr     <= dump_base;
        remaining    <= sat_len(dump_len);
      end
      if (m_valid && axis.m_axis_tready) begin
        cur_addr  <= cur_addr + 8'd1;
        remaining <= remaining - 9'd1;
        if (dump_done) dump_pending <= 1'b0;
      end
    end
  end

  // ---- stage p0: FIFO head captured for commit ----
  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wptr[PTR_W-1:0]] <= axis.s_axis_tdata;
    if (pop)  beat_p0 <= fifo_mem[rptr[PTR_W-1:0]];
  end

  // ---- commit: RAM write port shared by clear sweep and command commits ----
  always_ff @(posedge aclk) begin
    if (!areset) begin
      if (vld_p0 && fmt_ok(beat_p0)) mem[beat_p0[23:16]] <= beat_p0[7:0];
      else if (state == CLEAR)       mem[clr_addr]       <= 8'h00;
    end
    if (rd_en) rdata_q <= mem[cur_addr];
  end

`ifdef SINK_RDPORT_EN
  always_ff @(posedge aclk) begin
    if (areset) rd_data <= 8'h00;
    else        rd_data <= mem[rd_addr];
  end
`else
  // Side port disabled: reads always return zero.
  assign rd_data = rd_addr & 8'h00;
`endif
endmodule

// File: tb/tb_axis_hist_ram_sink.sv
// Scoreboard bench for axis_hist_ram_sink: directed commands and dumps, expected dump beats
// queued at issue time and checked by an independent output monitor.
module tb_axis_hist_ram_sink;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        dump_start = 1'b0;
  logic [7:0]  dump_base = 8'h00;
  logic [8:0]  dump_len = 9'd0;
  logic        busy;
  logic [31:0] wr_count;
  logic        err_fmt;
  logic [7:0]  rd_addr = 8'h00;
  logic [7:0]  rd_data;

  always #5 aclk = ~aclk;

  axis_hist_ram_sink_if ifc ();

  axis_hist_ram_sink dut (
    .aclk       (aclk),
    .areset     (areset),
    .axis       (ifc),
    .dump_start (dump_start),
    .dump_base  (dump_base),
    .dump_len   (dump_len),
    .busy       (busy),
    .wr_count   (wr_count),
    .err_fmt    (err_fmt),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] model_mem [256];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic settle;
    repeat (4) tick;
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    ifc.s_axis_tdata  = d;
    ifc.s_axis_tvalid = 1'b1;
    #0;
    while (!ifc.s_axis_tready && n < 500) begin
      tick;
      n++;
    end
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no tready want tready for %h", d);
    end else begin
      if (d[31:24] == 8'h00 && d[15:8] == 8'h00) model_mem[d[23:16]] = d[7:0];
    end
    tick;
    ifc.s_axis_tvalid = 1'b0;
  endtask

  task automatic dump(input logic [7:0] base, input logic [8:0] len);
    dump_base  = base;
    dump_len   = len;
    dump_start = 1'b1;
    tick;
    dump_start = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 2000) begin
      tick;
      n++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic rd_check(input logic [7:0] a);
    logic [7:0] e;
    rd_addr = a;
    tick;
`ifdef SINK_RDPORT_EN
    e = model_mem[a];
`else
    e = 8'h00;
`endif
    chk("rd_data", 32'(rd_data), 32'(e));
  endtask

  task automatic zero_checks;
    chk("rst_tready", 32'(ifc.s_axis_tready), 32'd0);
    chk("rst_tvalid", 32'(ifc.m_axis_tvalid), 32'd0);
    chk("rst_tdata",  ifc.m_axis_tdata, 32'd0);
    chk("rst_tlast",  32'(ifc.m_axis_tlast), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_wr_count", wr_count, 32'd0);
    chk("rst_err_fmt", 32'(err_fmt), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
  endtask

  task automatic wait_clear;
    int nb;
    int nr;
    nb = 0;
    nr = 0;
    areset = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    #1;
    while (busy && nb < 400) begin
      if (!ifc.s_axis_tready) nr++;
      nb++;
      tick;
    end
    chk("clear_busy_cycles", 32'(nb), 32'd256);
    chk("clear_tready_low", 32'(nr), 32'd256);
    chk("idle_tready", 32'(ifc.s_axis_tready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  // Output monitor: stall stability and scoreboard comparison on every handshake.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    beat_t       e;
    prev_stall = 1'b0;
    prev_data  = 32'h0;
    prev_last  = 1'b0;
    forever begin
      @(negedge aclk);
      if (!areset && ifc.m_axis_tvalid) begin
        if (prev_stall) begin
          chk("hold_data", ifc.m_axis_tdata, prev_data);
          chk("hold_last", 32'(ifc.m_axis_tlast), 32'(prev_last));
        end
        if (ifc.m_axis_tready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got %h want no beat", ifc.m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", ifc.m_axis_tdata, e.data);
            chk("beat_last", 32'(ifc.m_axis_tlast), 32'(e.last));
          end
        end
        prev_stall = !ifc.m_axis_tready;
        prev_data  = ifc.m_axis_tdata;
        prev_last  = ifc.m_axis_tlast;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int n;
    ifc.s_axis_tdata  = 32'h0;
    ifc.s_axis_tvalid = 1'b0;
    ifc.m_axis_tready = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

    // Reset and self-clear
    repeat (3) tick;
    zero_checks;
    wait_clear;
    rd_check(8'h00);
    rd_check(8'h7F);
    rd_check(8'hFF);

    // Two well-formed writes, then a 2-beat dump
    send(32'h0004_0003);
    send(32'h0025_00A7);
    settle;
    chk("wr_count_2", wr_count, 32'd2);
    rd_check(8'h04);
    rd_check(8'h25);
    expect_beat(32'h0004_0003, 1'b0);
    expect_beat(32'h0005_0000, 1'b1);
    dump(8'h04, 9'd2);
    wait_idle;
    settle;
    chk("q_empty_dump1", 32'(exp_q.size()), 32'd0);

    // Malformed command
    send(32'h0110_0055);
    settle;
    chk("err_fmt_set", 32'(err_fmt), 32'd1);
    chk("wr_count_malformed", wr_count, 32'd2);
    rd_check(8'h10);
    expect_beat(32'h0010_0000, 1'b1);
    dump(8'h10, 9'd1);
    wait_idle;

    // Zero-length dump is ignored
    dump(8'h00, 9'd0);
    chk("len0_busy", 32'(busy), 32'd0);

    // Input blocked by a pending dump; snapshot includes the beat accepted before it
    send(32'h0040_0011);
    ifc.m_axis_tready = 1'b0;
    expect_beat(32'h0040_0011, 1'b0);
    expect_beat(32'h0041_0000, 1'b0);
    expect_beat(32'h0042_0000, 1'b0);
    expect_beat(32'h0043_0000, 1'b1);
    dump(8'h40, 9'd4);
    fork
      begin
        send(32'h0040_0021);
        send(32'h0041_0022);
        send(32'h0040_0023);
        send(32'h0042_0024);
        send(32'h0043_0025);
        send(32'h0041_0026);
      end
      begin
        repeat (10) tick;
        chk("blocked_tready", 32'(ifc.s_axis_tready), 32'd0);
        chk("blocked_busy", 32'(busy), 32'd1);
        ifc.m_axis_tready = 1'b1;
      end
    join
    settle;
    chk("wr_count_9", wr_count, 32'd9);
    expect_beat(32'h0040_0023, 1'b0);
    expect_beat(32'h0041_0026, 1'b0);
    expect_beat(32'h0042_0024, 1'b0);
    expect_beat(32'h0043_0025, 1'b1);
    dump(8'h40, 9'd4);
    wait_idle;

    // Address wrap with a stalling sink
    send(32'h00FF_00C3);
    settle;
    expect_beat(32'h00FE_0000, 1'b0);
    expect_beat(32'h00FF_00C3, 1'b0);
    expect_beat(32'h0000_0000, 1'b1);
    dump(8'hFE, 9'd3);
    n = 0;
    while (busy && n < 200) begin
      ifc.m_axis_tready = !ifc.m_axis_tready;
      tick;
      n++;
    end
    ifc.m_axis_tready = 1'b1;
    chk("wrap_done", 32'(busy), 32'd0);

    // Over-long request saturates to a full 256-beat sweep
    for (int i = 0; i < 256; i++)
      expect_beat({8'h00, 8'(i), 8'h00, model_mem[i]}, (i == 255));
    dump(8'h00, 9'd300);
    wait_idle;
    settle;
    chk("q_empty_sat", 32'(exp_q.size()), 32'd0);

    // Reset during the second beat of a 4-beat dump
    expect_beat(32'h0004_0003, 1'b0);
    expect_beat(32'h0005_0000, 1'b0);
    expect_beat(32'h0006_0000, 1'b0);
    expect_beat(32'h0007_0000, 1'b1);
    dump(8'h04, 9'd4);
    n = 0;
    while (!(ifc.m_axis_tvalid && ifc.m_axis_tdata[23:16] == 8'h05) && n < 50) begin
      tick;
      n++;
    end
    chk("second_beat_seen", 32'(ifc.m_axis_tvalid), 32'd1);
    areset = 1'b1;
    tick;
    chk("abort_tvalid", 32'(ifc.m_axis_tvalid), 32'd0);
    chk("abort_q_left", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    tick;
    zero_checks;
    wait_clear;
    expect_beat(32'h0004_0000, 1'b1);
    dump(8'h04, 9'd1);
    wait_idle;
    settle;
    chk("q_empty_end", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
